sound_mailbox: RTL and testbench

Command/response mailbox and sound-CPU sequencer between the 68k main CPU and the 6502 sound CPU of the sound board. It latches 68k command bytes and NMIs the 6502 for each one. It latches 6502 response bytes and raises a 68k interrupt. It also owns the sound CPU reset line (SNDRST_b), including a timed hold after power-up and 68k-commanded sound resets.

---
 rtl/sound_mailbox.sv | 130 +++++++++++++
 tb/tb_sound_mailbox.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sound_mailbox.sv
// sound_mailbox: 68k <-> 6502 command/response mailbox with NMI pulser and sound-CPU reset sequencer.
module sound_mailbox #(
  parameter int NMI_PULSE   = 8,
  parameter int NMI_HOLDOFF = 16,
  parameter int RST_CYCLES  = 32
) (
  input  logic       phi0,
  input  logic       rst,
  input  logic       m68k_wr_cmd,
  input  logic [7:0] m68k_din,
  input  logic       m68k_rd_resp,
  input  logic       m68k_snd_reset,
  output logic [7:0] m68k_dout,
  output logic [3:0] m68k_status,
  output logic       m68k_irq,
  input  logic       s_rd_cmd,
  input  logic       s_wr_resp,
  input  logic [7:0] s_din,
  output logic [7:0] s_cmd,
  output logic [7:0] s_status,
  output logic       SNDNMI_b,
  output logic       SNDRST_b
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int NW = $clog2((NMI_PULSE > NMI_HOLDOFF ? NMI_PULSE : NMI_HOLDOFF) + 1);
  typedef enum logic {S_HOLD, S_RUN} seq_t;
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} nmi_t;
  seq_t seq, seq_n;
  nmi_t nst, nst_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [NW-1:0] ncnt, ncnt_n;
  logic pend, pend_n;
  logic [7:0] cmd, cmd_n, resp, resp_n;
  logic cmd_full, cmd_full_n, resp_full, resp_full_n, cmd_ovr, cmd_ovr_n, resp_ovr, resp_ovr_n;
  logic run, wr_c, rd_c, wr_r, rd_r, req;
  assign run  = seq == S_RUN;
  assign wr_c = run & m68k_wr_cmd;
  assign rd_c = run & s_rd_cmd;
  assign wr_r = run & s_wr_resp;
  assign rd_r = run & m68k_rd_resp;
  assign req  = wr_c | pend;
  always_comb begin
    seq_n       = seq;
    rcnt_n      = rcnt;
    nst_n       = nst;
    ncnt_n      = ncnt;
    pend_n      = pend;
    cmd_n       = wr_c ? m68k_din : cmd;
    cmd_full_n  = wr_c | (cmd_full & ~rd_c);
    cmd_ovr_n   = cmd_ovr | (wr_c & cmd_full & ~rd_c);
    resp_n      = wr_r ? s_din : resp;
    resp_full_n = wr_r | (resp_full & ~rd_r);
    resp_ovr_n  = resp_ovr | (wr_r & resp_full & ~rd_r);
    if (!run) begin
      rcnt_n = rcnt - 1'b1;
      seq_n  = rcnt == RW'(1) ? S_RUN : S_HOLD;
    end
    // A pending request leaving HOLDOFF starts its pulse on that same edge, so
    // back-to-back pulses are spaced exactly NMI_PULSE+NMI_HOLDOFF apart.
    case (nst)
      IDLE: begin
        nst_n  = req ? PULSE : IDLE;
        ncnt_n = req ? NW'(NMI_PULSE - 1) : ncnt;
        pend_n = 1'b0;
      end
      PULSE: begin
        nst_n  = ncnt == '0 ? HOLDOFF : PULSE;
        ncnt_n = ncnt == '0 ? NW'(NMI_HOLDOFF - 1) : ncnt - 1'b1;
        pend_n = req;
      end
      HOLDOFF: begin
        nst_n  = ncnt != '0 ? HOLDOFF : req ? PULSE : IDLE;
        ncnt_n = ncnt != '0 ? ncnt - 1'b1 : NW'(NMI_PULSE - 1);
        pend_n = ncnt != '0 ? req : 1'b0;
      end
      default: begin
        nst_n  = IDLE;
        ncnt_n = '0;
        pend_n = 1'b0;
      end
    endcase
    if (m68k_snd_reset) begin
      seq_n       = S_HOLD;
      rcnt_n      = RW'(RST_CYCLES);
      nst_n       = IDLE;
      ncnt_n      = '0;
      pend_n      = 1'b0;
      cmd_n       = '0;
      resp_n      = '0;
      cmd_full_n  = 1'b0;
      resp_full_n = 1'b0;
      cmd_ovr_n   = 1'b0;
      resp_ovr_n  = 1'b0;
    end
  end
  always_ff @(posedge phi0 or posedge rst) begin
    if (rst) begin
      seq       <= S_HOLD;
      rcnt      <= RW'(RST_CYCLES);
      nst       <= IDLE;
      ncnt      <= '0;
      pend      <= 1'b0;
      cmd       <= '0;
      resp      <= '0;
      cmd_full  <= 1'b0;
      resp_full <= 1'b0;
      cmd_ovr   <= 1'b0;
      resp_ovr  <= 1'b0;
    end else begin
      seq       <= seq_n;
      rcnt      <= rcnt_n;
      nst       <= nst_n;
      ncnt      <= ncnt_n;
      pend      <= pend_n;
      cmd       <= cmd_n;
      resp      <= resp_n;
      cmd_full  <= cmd_full_n;
      resp_full <= resp_full_n;
      cmd_ovr   <= cmd_ovr_n;
      resp_ovr  <= resp_ovr_n;
    end
  end
  assign m68k_dout   = resp;
  assign m68k_status = {cmd_ovr, resp_ovr, cmd_full, resp_full};
  assign m68k_irq    = resp_full;
  assign s_cmd       = cmd;
  assign s_status    = {cmd_full, resp_full, 6'b0};
  assign SNDNMI_b    = nst != PULSE;
  assign SNDRST_b    = seq == S_RUN;
endmodule

// File: tb/tb_sound_mailbox.sv
// tb_sound_mailbox: randomized scoreboard bench; a time-based reference model predicts every cycle's outputs.
module tb_sound_mailbox;
  localparam int P = 8, H = 16, R = 32;
  logic phi0 = 1'b0, rst = 1'b1;
  logic m68k_wr_cmd = 0, m68k_rd_resp = 0, m68k_snd_reset = 0, s_rd_cmd = 0, s_wr_resp = 0;
  logic [7:0] m68k_din = 0, s_din = 0, m68k_dout, s_cmd, s_status;
  logic [3:0] m68k_status;
  logic m68k_irq, SNDNMI_b, SNDRST_b;
  sound_mailbox #(.NMI_PULSE(P), .NMI_HOLDOFF(H), .RST_CYCLES(R)) dut (
    .phi0(phi0), .rst(rst), .m68k_wr_cmd(m68k_wr_cmd), .m68k_din(m68k_din),
    .m68k_rd_resp(m68k_rd_resp), .m68k_snd_reset(m68k_snd_reset), .m68k_dout(m68k_dout),
    .m68k_status(m68k_status), .m68k_irq(m68k_irq), .s_rd_cmd(s_rd_cmd), .s_wr_resp(s_wr_resp),
    .s_din(s_din), .s_cmd(s_cmd), .s_status(s_status), .SNDNMI_b(SNDNMI_b), .SNDRST_b(SNDRST_b)
  );
  always #5 phi0 = ~phi0;
  typedef struct packed {
    logic [7:0] cmd, resp;
    logic [3:0] mst;
    logic [7:0] sst;
    logic irq, nmi, rstb;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int cyc, hold_until, last_start;
  logic pending, m_cf, m_rf, m_co, m_ro;
  logic [7:0] m_cmd, m_resp;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    cyc = 0; hold_until = R; last_start = -1000; pending = 0;
    m_cf = 0; m_rf = 0; m_co = 0; m_ro = 0; m_cmd = 0; m_resp = 0;
  endtask
  // Drive one cycle of strobes (called at a negedge), predict the post-edge outputs, wait past the edge.
  task automatic cycle(input logic wc, input logic [7:0] cd, input logic rr, input logic sr,
                       input logic rc, input logic wr, input logic [7:0] rd);
    logic run, wacc;
    exp_t e;
    m68k_wr_cmd = wc; m68k_din = cd; m68k_rd_resp = rr; m68k_snd_reset = sr;
    s_rd_cmd = rc; s_wr_resp = wr; s_din = rd;
    run = cyc >= hold_until;
    cyc++;
    wacc = !sr && run && wc;
    if (sr) begin
      m_cf = 0; m_rf = 0; m_co = 0; m_ro = 0; m_cmd = 0; m_resp = 0;
      hold_until = cyc + R; last_start = -1000; pending = 0;
    end else if (run) begin
      if (wc) begin
        if (m_cf && !rc) m_co = 1;
        m_cmd = cd; m_cf = 1;
      end else if (rc) m_cf = 0;
      if (wr) begin
        if (m_rf && !rr) m_ro = 1;
        m_resp = rd; m_rf = 1;
      end else if (rr) m_rf = 0;
    end
    if ((wacc || pending) && cyc >= last_start + P + H) begin
      last_start = cyc; pending = 0;
    end else if (wacc) pending = 1;
    e.cmd = m_cmd; e.resp = m_resp; e.mst = {m_co, m_ro, m_cf, m_rf};
    e.sst = {m_cf, m_rf, 6'b0}; e.irq = m_rf;
    e.nmi = !(cyc < last_start + P); e.rstb = cyc >= hold_until;
    q.push_back(e);
    @(posedge phi0);
    @(negedge phi0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_s_cmd", s_cmd, 0); chk("rst_dout", m68k_dout, 0);
    chk("rst_mstatus", m68k_status, 0); chk("rst_sstatus", s_status, 0);
    chk("rst_irq", m68k_irq, 0); chk("rst_nmi", SNDNMI_b, 1); chk("rst_sndrst", SNDRST_b, 0);
  endtask
  always @(posedge phi0) begin
    exp_t e;
    #2;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk("s_cmd", s_cmd, e.cmd); chk("m68k_dout", m68k_dout, e.resp);
      chk("m68k_status", m68k_status, e.mst); chk("s_status", s_status, e.sst);
      chk("m68k_irq", m68k_irq, e.irq); chk("SNDNMI_b", SNDNMI_b, e.nmi);
      chk("SNDRST_b", SNDRST_b, e.rstb);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge phi0);
    chk_reset_vals();
    rst = 0;
    model_reset();
    idle(35);
    cycle(1, 8'h5A, 0, 0, 0, 0, 0);
    idle(10);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(25);
    cycle(1, 8'h01, 0, 0, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0, 0, 0);
    cycle(1, 8'h03, 0, 0, 0, 0, 0);
    idle(50);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 8'hC3);
    idle(1);
    cycle(0, 0, 1, 0, 0, 1, 8'h44);
    idle(2);
    cycle(1, 8'hA5, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h77, 0, 0, 0, 1, 8'h66);
    idle(35);
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 8'($urandom));
    idle(40);
    cycle(1, 8'h3C, 0, 0, 0, 0, 0);
    idle(1);
    #2;
    rst = 1;
    #1;
    chk_reset_vals();
    @(negedge phi0);
    chk_reset_vals();
    q.delete();
    rst = 0;
    model_reset();
    idle(40);
    cycle(1, 8'h99, 0, 0, 0, 0, 0);
    idle(30);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
